// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver clocked by sysclk, sampling on rising edges of the 16x bclk level input.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1); the port list is the same in both builds.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sysclk,
  input  logic                 resetb,
  input  logic                 bclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] NBIT = BW'(DATA_BITS - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] AFTER  = PARITY;
  logic par_bad;
`else
  localparam logic [2:0] AFTER  = STOP;
`endif
  logic [2:0] state;
  logic rx_m, rx_s, rx_prev, bclk_d;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic tick, good;
  assign tick    = bclk & ~bclk_d;
  assign rx_busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  assign good = rx_s & ~par_bad;
`else
  assign good = rx_s;
`endif
  always_ff @(posedge sysclk) begin
    if (!resetb) begin
      state    <= IDLE;
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      bclk_d   <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_prev  <= rx_s;
      bclk_d   <= bclk;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        IDLE: if (rx_prev && !rx_s) begin
          state    <= START;
          tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
        end
        START: if (tick && tick_cnt == MID) begin
          state    <= rx_s ? IDLE : DATA;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        // tick_cnt wraps on its own, so each later sample lands a full bit after the start mid-point
        DATA: if (tick && tick_cnt == LAST) begin
          shift   <= {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == NBIT) state <= AFTER;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick && tick_cnt == LAST) begin
          par_bad <= ^{shift, rx_s};
          state   <= STOP;
        end
`endif
        STOP: if (tick && tick_cnt == LAST) begin
          if (good) rx_data <= shift;
          rx_valid <= good;
          rx_err   <= ~good;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
